// File: rtl/riscv_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU operation codes,
// forwarding-source selector and the default datapath widths.
package riscv_pkg;

    // Default datapath geometry
    localparam int DATA_WIDTH_DEF    = 32;
    localparam int OPCODE_LENGTH_DEF = 4;
    localparam int REG_ADDR_W_DEF    = 5;

    // ALU operation codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_EQ    = 4'b1000;
    localparam logic [3:0] ALU_NE    = 4'b1001;
    localparam logic [3:0] ALU_LT    = 4'b1010;
    localparam logic [3:0] ALU_GE    = 4'b1011;
    localparam logic [3:0] ALU_SLT   = 4'b1100;
    localparam logic [3:0] ALU_PASSB = 4'b1110;
    // The ALU yields zero for this code, so a bubble is harmless downstream
    localparam logic [3:0] ALU_NOP   = 4'b1111;

    // Where a forwarded operand comes from
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_WB   = 2'd1,
        FWD_EXM  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Forwarding select and 3:1 operand mux for one source register held in EX.
// The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
module operand_fwd_mux
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic [REG_ADDR_W-1:0] exm_rd_addr,
    input  logic                  exm_reg_write,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    fwd_sel_t sel;
    logic     src_nonzero;
    logic     exm_hit;
    logic     wb_hit;

    // Pick the newest producer of this source register, EX/MEM first
    always_comb begin
        sel         = FWD_NONE;
        src_nonzero = (src_addr != '0);
        exm_hit     = exm_reg_write && src_nonzero && (exm_rd_addr == src_addr);
        wb_hit      = wb_reg_write && src_nonzero && (wb_rd_addr == src_addr);
        if (exm_hit) begin
            sel = FWD_EXM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    // Route the selected source onto the operand
    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_EXM:  fwd_data = exm_result;
            FWD_WB:   fwd_data = wb_result;
            default:  fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding in front of the ALU.
// Captures the decoded instruction each cycle, turns it into a bubble on a
// branch flush or load-use hazard, and resolves RAW hazards from EX/MEM and
// MEM/WB so SrcA/SrcB/Operation can feed the ALU directly.
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int OPCODE_LENGTH = OPCODE_LENGTH_DEF,
    parameter int REG_ADDR_W    = REG_ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
    input  logic [REG_ADDR_W-1:0]    id_rd_addr,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alu_src,
    input  logic                     id_a_is_pc,
    input  logic                     id_mem_read,
    input  logic                     id_reg_write,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exm_rd_addr,
    input  logic                     exm_reg_write,
    input  logic [DATA_WIDTH-1:0]    exm_result,
    input  logic [REG_ADDR_W-1:0]    wb_rd_addr,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     stall_req,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR_W-1:0]    ex_rd_addr,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read
);

    // Everything the EX stage needs about one instruction
    typedef struct packed {
        logic                     valid;
        logic [REG_ADDR_W-1:0]    rs1_addr;
        logic [REG_ADDR_W-1:0]    rs2_addr;
        logic [REG_ADDR_W-1:0]    rd_addr;
        logic [DATA_WIDTH-1:0]    rs1_data;
        logic [DATA_WIDTH-1:0]    rs2_data;
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    pc;
        logic [OPCODE_LENGTH-1:0] alu_op;
        logic                     alu_src;
        logic                     a_is_pc;
        logic                     mem_read;
        logic                     reg_write;
    } id_ex_t;

    id_ex_t                ex_q;
    id_ex_t                captured;
    id_ex_t                bubble;
    logic                  load_use;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // Build the two candidate register contents: the ID instruction or a bubble
    always_comb begin
        captured           = '0;
        captured.valid     = id_valid;
        captured.rs1_addr  = id_rs1_addr;
        captured.rs2_addr  = id_rs2_addr;
        captured.rd_addr   = id_rd_addr;
        captured.rs1_data  = id_rs1_data;
        captured.rs2_data  = id_rs2_data;
        captured.imm       = id_imm;
        captured.pc        = id_pc;
        captured.alu_op    = id_alu_op;
        captured.alu_src   = id_alu_src;
        captured.a_is_pc   = id_a_is_pc;
        captured.mem_read  = id_mem_read;
        captured.reg_write = id_reg_write;

        bubble        = '0;
        bubble.alu_op = OPCODE_LENGTH'(ALU_NOP);
    end

    // A load in EX whose destination is read by the ID instruction must be
    // separated by one bubble; a flush kills the ID instruction anyway
    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0)
                   && ((ex_q.rd_addr == id_rs1_addr) || (ex_q.rd_addr == id_rs2_addr));
        stall_req = !reset && !flush && id_valid && load_use;
    end

    // ID/EX register: reset, then flush/stall bubble, then normal capture
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= bubble;
        end else if (flush || stall_req) begin
            ex_q <= bubble;
        end else begin
            ex_q <= captured;
        end
    end

    operand_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .src_addr      (ex_q.rs1_addr),
        .reg_data      (ex_q.rs1_data),
        .exm_rd_addr   (exm_rd_addr),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs1)
    );

    operand_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .src_addr      (ex_q.rs2_addr),
        .reg_data      (ex_q.rs2_data),
        .exm_rd_addr   (exm_rd_addr),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs2)
    );

    // Operand selection for the ALU; operands are forced to zero under reset
    always_comb begin
        SrcA = ex_q.a_is_pc ? ex_q.pc  : fwd_rs1;
        SrcB = ex_q.alu_src ? ex_q.imm : fwd_rs2;
        if (reset) begin
            SrcA = '0;
            SrcB = '0;
        end
    end

    // Remaining EX outputs; side-effect controls only act for real instructions
    always_comb begin
        ex_valid      = ex_q.valid;
        Operation     = ex_q.alu_op;
        ex_store_data = fwd_rs2;
        ex_rd_addr    = ex_q.rd_addr;
        ex_reg_write  = ex_q.valid && ex_q.reg_write;
        ex_mem_read   = ex_q.valid && ex_q.mem_read;
    end

endmodule
